// File: rtl/msu_pkg.sv
// Shared constants and types for the MSU1 data channel: register map, status layout, ID string
// and the seek FSM states.
package msu_pkg;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_SEEK0  = 3'd0;
  localparam logic [2:0] REG_SEEK1  = 3'd1;
  localparam logic [2:0] REG_SEEK2  = 3'd2;
  localparam logic [2:0] REG_SEEK3  = 3'd3;

  localparam int unsigned STATUS_BUSY_BIT  = 7;
  localparam int unsigned STATUS_AUDIO_LSB = 3;
  localparam int unsigned STATUS_VER_LSB   = 0;

  localparam logic [47:0] MSU_ID = "S-MSU1";

  typedef enum logic [1:0] {
    StIdle,
    StSeekAck,
    StSeekDone
  } msu_state_e;

  // ID characters live at $2002-$2007, first character at the lowest address.
  function automatic logic [7:0] msu_id_byte(input logic [2:0] addr);
    logic [7:0] b;
    case (addr)
      3'd2:    b = MSU_ID[47:40];
      3'd3:    b = MSU_ID[39:32];
      3'd4:    b = MSU_ID[31:24];
      3'd5:    b = MSU_ID[23:16];
      3'd6:    b = MSU_ID[15:8];
      3'd7:    b = MSU_ID[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/msu_pulse_stretch.sv
// Retriggerable pulse stretcher: output stays high for exactly Hold cycles after the last trigger.
module msu_pulse_stretch #(
  parameter int unsigned Hold = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  input  logic clr_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (Hold > 1) ? $clog2(Hold) : 1;
  localparam logic [CntW-1:0] Load = CntW'(Hold - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            pulse_d, pulse_q;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    if (clr_i) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (trig_i) begin
      cnt_d   = Load;
      pulse_d = 1'b1;
    end else if (pulse_q) begin
      if (cnt_q == '0) begin
        pulse_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/msu_data_port.sv
// SNES-side MSU1 data port: register decode, seek handshake and byte streaming to msu_data_store.
// Optional build macro MSU_DATA_CLAMP_EN stops reads at data_size.
module msu_data_port
  import msu_pkg::*;
#(
  parameter int unsigned NEXT_HOLD = 16,
  parameter logic [2:0]  VERSION   = 3'd1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [2:0]  bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  input  logic [3:0]  audio_status,
  input  logic [31:0] data_size,
  output logic [31:0] rd_addr,
  output logic        rd_seek,
  input  logic        rd_seek_done,
  output logic        rd_next,
  input  logic [7:0]  rd_dout,
  output logic        data_busy
);

  msu_state_e  state_d, state_q;
  logic [31:0] latch_d, latch_q;
  logic [31:0] rd_addr_d, rd_addr_q;
  logic        rd_seek_d, rd_seek_q;
  logic        data_busy_d, data_busy_q;
  logic        pending_d, pending_q;

  logic wr_seek3, rd_data, at_end, next_trig, next_clr;

  assign wr_seek3  = bus_wr && (bus_addr == REG_SEEK3);
  // A simultaneous write suppresses the read side effect.
  assign rd_data   = bus_rd && !bus_wr && (bus_addr == REG_DATA);
  assign next_trig = rd_data && (state_q == StIdle) && !at_end;

`ifdef MSU_DATA_CLAMP_EN
  assign at_end = (rd_addr_q >= data_size);
`else
  assign at_end = 1'b0;
  logic unused_data_size;
  assign unused_data_size = ^data_size;
`endif

  always_comb begin
    state_d     = state_q;
    latch_d     = latch_q;
    rd_addr_d   = rd_addr_q;
    rd_seek_d   = rd_seek_q;
    data_busy_d = data_busy_q;
    pending_d   = pending_q;
    next_clr    = 1'b0;

    if (bus_wr) begin
      case (bus_addr)
        REG_SEEK0: latch_d[7:0]   = bus_din;
        REG_SEEK1: latch_d[15:8]  = bus_din;
        REG_SEEK2: latch_d[23:16] = bus_din;
        REG_SEEK3: latch_d[31:24] = bus_din;
        default:   ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (wr_seek3) begin
          rd_addr_d   = {bus_din, latch_q[23:0]};
          data_busy_d = 1'b1;
          rd_seek_d   = 1'b1;
          next_clr    = 1'b1;
          state_d     = StSeekAck;
        end else if (next_trig) begin
          rd_addr_d = rd_addr_q + 32'd1;
        end
      end
      StSeekAck: begin
        rd_seek_d = 1'b1;
        if (wr_seek3) pending_d = 1'b1;
        if (!rd_seek_done) state_d = StSeekDone;
      end
      StSeekDone: begin
        if (wr_seek3) pending_d = 1'b1;
        if (rd_seek_done) begin
          rd_seek_d = 1'b0;
          // A late byte-3 write in this very cycle still counts as pending.
          if (pending_q || wr_seek3) begin
            pending_d = 1'b0;
            rd_addr_d = latch_d;
            next_clr  = 1'b1;
            state_d   = StSeekAck;
          end else begin
            data_busy_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      latch_q     <= '0;
      rd_addr_q   <= '0;
      rd_seek_q   <= 1'b0;
      data_busy_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      latch_q     <= latch_d;
      rd_addr_q   <= rd_addr_d;
      rd_seek_q   <= rd_seek_d;
      data_busy_q <= data_busy_d;
      pending_q   <= pending_d;
    end
  end

  msu_pulse_stretch #(
    .Hold (NEXT_HOLD)
  ) u_next_stretch (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .trig_i  (next_trig),
    .clr_i   (next_clr),
    .pulse_o (rd_next)
  );

  always_comb begin
    bus_dout = 8'h00;
    case (bus_addr)
      REG_STATUS: begin
        bus_dout[STATUS_BUSY_BIT]                = data_busy_q;
        bus_dout[STATUS_AUDIO_LSB +: 4]          = audio_status;
        bus_dout[STATUS_VER_LSB +: 3]            = VERSION;
      end
      REG_DATA:   bus_dout = ((state_q == StIdle) && !at_end) ? rd_dout : 8'h00;
      default:    bus_dout = msu_id_byte(bus_addr);
    endcase
  end

  assign rd_addr   = rd_addr_q;
  assign rd_seek   = rd_seek_q;
  assign data_busy = data_busy_q;

endmodule

// File: tb/tb_msu_data_port.sv
// Bench for msu_data_port: expected read bytes go through a scoreboard queue checked on each
// bus_rd pulse; a behavioural store model answers seeks and supplies data bytes.
module tb_msu_data_port;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_din = '0;
  logic [7:0]  bus_dout;
  logic [3:0]  audio_status = '0;
  logic [31:0] data_size = 32'h100;
  logic [31:0] rd_addr;
  logic        rd_seek;
  logic        rd_seek_done;
  logic        rd_next;
  logic [7:0]  rd_dout;
  logic        data_busy;

  msu_data_port dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .bus_addr     (bus_addr),
    .bus_rd       (bus_rd),
    .bus_wr       (bus_wr),
    .bus_din      (bus_din),
    .bus_dout     (bus_dout),
    .audio_status (audio_status),
    .data_size    (data_size),
    .rd_addr      (rd_addr),
    .rd_seek      (rd_seek),
    .rd_seek_done (rd_seek_done),
    .rd_next      (rd_next),
    .rd_dout      (rd_dout),
    .data_busy    (data_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Store data: each byte is derived from its offset.
  assign rd_dout = rd_addr[7:0] ^ 8'hA5;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  int          widths[$];
  logic [7:0]  mon_exp;
  logic [31:0] exp_addr;
  logic        prev_seek;
  logic        stayed_busy;
  logic [7:0]  id_tab[8] = '{8'h00, 8'h00, 8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h31};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Store seek handshake model: done falls 3 cycles after a seek edge, rises 10 later.
  initial begin
    rd_seek_done = 1'b1;
    forever begin
      @(posedge rd_seek);
      repeat (3) @(posedge clk_sys);
      #1 rd_seek_done = 1'b0;
      repeat (10) @(posedge clk_sys);
      #1 rd_seek_done = 1'b1;
    end
  end

  // Scoreboard monitor for read data.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset_n && bus_rd) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_read: got %h at addr %0d, expected no read", bus_dout, bus_addr);
        end else begin
          mon_exp = exp_q.pop_front();
          check("bus_dout", 32'(bus_dout), 32'(mon_exp));
        end
      end
    end
  end

  // rd_next pulse width recorder.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk_sys);
      if (rd_next) begin
        w++;
      end else if (w != 0) begin
        widths.push_back(w);
        w = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    bus_addr = a; bus_din = d; bus_wr = 1'b1;
    @(posedge clk_sys); #1;
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    @(posedge clk_sys); #1;
    bus_addr = a; bus_rd = 1'b1;
    @(posedge clk_sys); #1;
    bus_rd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    prev_seek = rd_seek;
    for (int k = 0; k < 200 && data_busy; k++) begin
      prev_seek = rd_seek;
      @(posedge clk_sys); #1;
    end
    check({name, "_busy_clear"}, 32'(data_busy), 32'd0);
    check({name, "_seek_held"}, 32'(prev_seek), 32'd1);
    check({name, "_seek_clear"}, 32'(rd_seek), 32'd0);
  endtask

  task automatic do_seek(input logic [31:0] a, input string name);
    bus_write(3'd0, a[7:0]);
    bus_write(3'd1, a[15:8]);
    bus_write(3'd2, a[23:16]);
    bus_write(3'd3, a[31:24]);
    check({name, "_addr"}, rd_addr, a);
    wait_idle(name);
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_rd_addr", rd_addr, 32'h0);
    check("rst_rd_seek", 32'(rd_seek), 32'd0);
    check("rst_rd_next", 32'(rd_next), 32'd0);
    check("rst_busy", 32'(data_busy), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    bus_read(3'd0, 8'h01);
    for (int i = 2; i < 8; i++) bus_read(3'(i), id_tab[i]);
    audio_status = 4'b1010;
    bus_read(3'd0, 8'h51);
    audio_status = 4'b0000;

    // First seek, with status and data reads while busy.
    widths.delete();
    bus_write(3'd0, 8'h78);
    bus_write(3'd1, 8'h56);
    bus_write(3'd2, 8'h34);
    bus_write(3'd3, 8'h12);
    check("seek1_addr", rd_addr, 32'h12345678);
    check("seek1_rd_seek", 32'(rd_seek), 32'd1);
    check("seek1_busy", 32'(data_busy), 32'd1);
    bus_read(3'd0, 8'h81);
    bus_read(3'd1, 8'h00);
    check("busy_read_addr", rd_addr, 32'h12345678);
    check("busy_read_next", 32'(rd_next), 32'd0);
    wait_idle("seek1");
    check("busy_read_no_pulse", 32'(widths.size()), 32'd0);
    bus_read(3'd0, 8'h01);

    // Streaming reads.
    widths.delete();
    exp_addr = 32'h12345678;
    for (int i = 0; i < 9; i++) begin
      bus_read(3'd1, exp_addr[7:0] ^ 8'hA5);
      exp_addr = exp_addr + 32'd1;
      repeat (38) @(posedge clk_sys);
    end
    repeat (20) @(posedge clk_sys);
    #1;
    check("stream_addr", rd_addr, 32'h12345681);
    check("stream_pulses", 32'(widths.size()), 32'd9);
    foreach (widths[i]) check("stream_width", 32'(widths[i]), 32'd16);

    // Back-to-back seek: second byte-3 write while busy.
    bus_write(3'd3, 8'hCD);
    check("seek2a_addr", rd_addr, 32'hCD345678);
    bus_write(3'd3, 8'hAB);
    stayed_busy = 1'b1;
    for (int k = 0; k < 100 && rd_addr != 32'hAB345678; k++) begin
      stayed_busy = stayed_busy & data_busy;
      @(posedge clk_sys); #1;
    end
    check("seek2b_addr", rd_addr, 32'hAB345678);
    check("seek2b_kept_busy", 32'(stayed_busy & data_busy), 32'd1);
    wait_idle("seek2b");
    check("seek2b_final_addr", rd_addr, 32'hAB345678);

    // Simultaneous read and write: write wins, no increment.
    widths.delete();
    exp_q.push_back(8'h78 ^ 8'hA5);
    @(posedge clk_sys); #1;
    bus_addr = 3'd1; bus_din = 8'h00; bus_rd = 1'b1; bus_wr = 1'b1;
    @(posedge clk_sys); #1;
    bus_rd = 1'b0; bus_wr = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rdwr_addr", rd_addr, 32'hAB345678);
    check("rdwr_no_next", 32'(rd_next), 32'd0);

    // End-of-data boundary.
    widths.delete();
    do_seek(32'h000000FF, "seek_ff");
    bus_read(3'd1, 8'hFF ^ 8'hA5);
    check("end_first_addr", rd_addr, 32'h00000100);
    repeat (20) @(posedge clk_sys);
`ifdef MSU_DATA_CLAMP_EN
    bus_read(3'd1, 8'h00);
    repeat (20) @(posedge clk_sys);
    #1;
    check("end_clamp_addr", rd_addr, 32'h00000100);
    check("end_clamp_pulses", 32'(widths.size()), 32'd1);
`else
    bus_read(3'd1, 8'h00 ^ 8'hA5);
    repeat (20) @(posedge clk_sys);
    #1;
    check("end_noclamp_addr", rd_addr, 32'h00000101);
    check("end_noclamp_pulses", 32'(widths.size()), 32'd2);
`endif

    // Address wrap at 2^32.
    do_seek(32'hFFFFFFFF, "seek_top");
`ifdef MSU_DATA_CLAMP_EN
    bus_read(3'd1, 8'h00);
    #1;
    check("wrap_addr", rd_addr, 32'hFFFFFFFF);
`else
    bus_read(3'd1, 8'hFF ^ 8'hA5);
    #1;
    check("wrap_addr", rd_addr, 32'h00000000);
`endif

    repeat (20) @(posedge clk_sys);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
